// File: rtl/scene_render.sv
// Pixel colour generator for a side-scrolling dinosaur game: two pipeline
// stages turn VGA row/column requests into a 12-bit colour every clock.
module scene_render #(
  parameter int GROUND_ROW = 400,
  parameter int DINO_COL   = 64,
  parameter int DINO_W     = 32,
  parameter int DINO_H     = 32
) (
  input  logic        CLK,
  input  logic        clrn,
  input  logic [8:0]  row_addr,
  input  logic [9:0]  col_addr,
  input  logic [5:0]  dinosaur_height,
  input  logic [5:0]  ground_position,
  input  logic        game_status,
  output logic [11:0] vga_data
);

  localparam logic [9:0] GROUND     = 10'(GROUND_ROW);
  localparam logic [9:0] TEX_FIRST  = 10'(GROUND_ROW + 1);
  localparam logic [9:0] TEX_LAST   = 10'(GROUND_ROW + 8);
  localparam logic [9:0] DINO_LEFT  = 10'(DINO_COL);
  localparam logic [9:0] DINO_RIGHT = 10'(DINO_COL + DINO_W - 1);
  localparam logic [9:0] DINO_SPAN  = 10'(DINO_H);

  localparam logic [11:0] C_BLANK  = 12'h000;
  localparam logic [11:0] C_BANNER = 12'h00F;
  localparam logic [11:0] C_RUN    = 12'h0A0;
  localparam logic [11:0] C_OVER   = 12'hF00;
  localparam logic [11:0] C_GROUND = 12'h555;
  localparam logic [11:0] C_TEX    = 12'h888;
  localparam logic [11:0] C_BG     = 12'hFFF;

  // Per-frame state
  logic       prev_origin;
  logic [5:0] h_snap;
  logic [5:0] gpos_snap;
  logic       status_snap;
  logic [5:0] frame_cnt;

  // Stage 1: address and snapshot-independent region flags
  logic       v1;
  logic [9:0] row1;
  logic [9:0] col1;
  logic       blank1;
  logic       banner1;
  logic       line1;
  logic       tex_rows1;
  logic       dino_cols1;

  logic [9:0] row_ext;
  logic       at_origin;
  logic       frame_start;
  logic       blank_c;
  logic       banner_c;
  logic       line_c;
  logic       tex_rows_c;
  logic       dino_cols_c;

  assign row_ext     = {1'b0, row_addr};
  assign at_origin   = (row_addr == 9'd0) && (col_addr == 10'd0);
  assign frame_start = at_origin && !prev_origin;

  assign blank_c     = (col_addr >= 10'd640) || (row_addr >= 9'd480);
  assign banner_c    = (row_ext >= 10'd200) && (row_ext <= 10'd231) &&
                       (col_addr >= 10'd256) && (col_addr <= 10'd383);
  assign line_c      = (row_ext == GROUND);
  assign tex_rows_c  = (row_ext >= TEX_FIRST) && (row_ext <= TEX_LAST);
  assign dino_cols_c = (col_addr >= DINO_LEFT) && (col_addr <= DINO_RIGHT);

  // Stage 2 terms that depend on the snapshots; they see the values taken
  // on the same edge the frame's first pixel entered stage 1.
  logic [9:0]  dino_top;
  logic [9:0]  dino_bot;
  logic        dino_hit;
  logic [3:0]  tex_phase;
  logic [11:0] pixel_c;

  assign dino_top  = GROUND - DINO_SPAN - {3'b000, h_snap, 1'b0};
  assign dino_bot  = dino_top + DINO_SPAN - 10'd1;
  assign dino_hit  = dino_cols1 && (row1 >= dino_top) && (row1 <= dino_bot);
  assign tex_phase = col1[3:0] + {gpos_snap[1:0], 2'b00};

  always_comb begin
    pixel_c = C_BG;
    if (!v1 || blank1)                        pixel_c = C_BLANK;
    else if (banner1 && status_snap && !frame_cnt[4]) pixel_c = C_BANNER;
    else if (dino_hit)                        pixel_c = status_snap ? C_OVER : C_RUN;
    else if (line1)                           pixel_c = C_GROUND;
    else if (tex_rows1 && (tex_phase < 4'd2)) pixel_c = C_TEX;
  end

  // NOTE: every register here is written with <= so all of them sample the
  // pre-edge values of each other, which is what keeps the stages aligned.
  always_ff @(posedge CLK) begin
    if (!clrn) begin
      prev_origin <= 1'b0;
      h_snap      <= '0;
      gpos_snap   <= '0;
      status_snap <= 1'b0;
      frame_cnt   <= '0;
      v1          <= 1'b0;
      row1        <= '0;
      col1        <= '0;
      blank1      <= 1'b0;
      banner1     <= 1'b0;
      line1       <= 1'b0;
      tex_rows1   <= 1'b0;
      dino_cols1  <= 1'b0;
      vga_data    <= C_BLANK;
    end else begin
      prev_origin <= at_origin;
      if (frame_start) begin
        h_snap      <= dinosaur_height;
        gpos_snap   <= ground_position;
        status_snap <= game_status;
        frame_cnt   <= frame_cnt + 6'd1;
      end
      v1         <= 1'b1;
      row1       <= row_ext;
      col1       <= col_addr;
      blank1     <= blank_c;
      banner1    <= banner_c;
      line1      <= line_c;
      tex_rows1  <= tex_rows_c;
      dino_cols1 <= dino_cols_c;
      vga_data   <= pixel_c;
    end
  end

endmodule
